// File: rtl/axi_lite_sram_s.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_sram_s
// Purpose  : AXI4-Lite slave in front of a DEPTH x DATA_W on-chip SRAM with
//            byte-lane write strobes and a configurable read latency.
//            The read and write channels run in independent state machines.
// Ports    : clk, rst           - clock (rising edge), synchronous reset
//            ar*/r*             - read address / read data channels
//            aw*/w*/b*          - write address / data / response channels
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_sram_s #(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 64,
  parameter int                DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  // read address channel
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  // read data channel
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  // write address channel
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  // write data channel
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  // write response channel
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int c_BYTES  = DATA_W / 8;
  localparam int c_OFF_W  = $clog2(c_BYTES);
  localparam int c_IDX_W  = $clog2(DEPTH);
  localparam int c_SPAN_W = c_OFF_W + c_IDX_W;
  // BASE is aligned to the array span, so "in range" reduces to the address
  // bits above the span matching those of BASE.
  localparam logic [ADDR_W-c_SPAN_W-1:0] c_BASE_HI  = BASE[ADDR_W-1:c_SPAN_W];
  localparam logic [3:0]                 c_LAT_INIT = 4'(RD_LAT - 1);
  localparam logic [1:0]                 c_OKAY     = 2'b00;
  localparam logic [1:0]                 c_DECERR   = 2'b11;

  // Storage: deliberately excluded from reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rstate_t;

  rstate_t            r_rstate;
  logic [3:0]         r_lat_cnt;
  logic               w_ar_hs;
  logic               w_ar_in;
  logic [c_IDX_W-1:0] w_ar_idx;

  assign w_ar_hs  = arvalid & arready;
  assign w_ar_in  = (araddr[ADDR_W-1:c_SPAN_W] == c_BASE_HI);
  assign w_ar_idx = araddr[c_SPAN_W-1:c_OFF_W];

  // The array word is sampled at the AR handshake edge; a write landing on
  // the same edge is a separate non-blocking update, so the read sees the
  // pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_lat_cnt <= '0;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rresp     <= 2'b00;
      rdata     <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          arready <= 1'b1;
          if (w_ar_hs) begin
            arready   <= 1'b0;
            rdata     <= w_ar_in ? r_mem[w_ar_idx] : '0;
            rresp     <= w_ar_in ? c_OKAY : c_DECERR;
            r_lat_cnt <= c_LAT_INIT;
            r_rstate  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_lat_cnt == 4'd0) begin
            rvalid   <= 1'b1;
            r_rstate <= R_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  wstate_t              r_wstate;
  logic                 r_aw_got;
  logic                 r_w_got;
  logic [ADDR_W-1:0]    r_awaddr;
  logic [DATA_W-1:0]    r_wdata;
  logic [c_BYTES-1:0]   r_wstrb;

  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_both;
  logic [ADDR_W-1:0]    w_aw_addr;
  logic [DATA_W-1:0]    w_wdata_eff;
  logic [c_BYTES-1:0]   w_wstrb_eff;
  logic                 w_aw_in;
  logic [c_IDX_W-1:0]   w_aw_idx;
  logic                 w_mem_we;

  assign w_aw_hs     = awvalid & awready;
  assign w_w_hs      = wvalid & wready;
  // Each half comes either from its capture register or from a handshake
  // completing on this very edge.
  assign w_aw_addr   = r_aw_got ? r_awaddr : awaddr;
  assign w_wdata_eff = r_w_got  ? r_wdata  : wdata;
  assign w_wstrb_eff = r_w_got  ? r_wstrb  : wstrb;
  assign w_both      = (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
  assign w_aw_in     = (w_aw_addr[ADDR_W-1:c_SPAN_W] == c_BASE_HI);
  assign w_aw_idx    = w_aw_addr[c_SPAN_W-1:c_OFF_W];
  // rst gating keeps a write from landing on the reset edge itself.
  assign w_mem_we    = ~rst & (r_wstate == W_IDLE) & w_both & w_aw_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_both) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= w_aw_in ? c_OKAY : c_DECERR;
            r_wstate <= W_RESP;
          end else begin
            if (w_aw_hs) begin
              r_aw_got <= 1'b1;
              r_awaddr <= awaddr;
            end
            if (w_w_hs) begin
              r_w_got <= 1'b1;
              r_wdata <= wdata;
              r_wstrb <= wstrb;
            end
            awready <= ~(r_aw_got | w_aw_hs);
            wready  <= ~(r_w_got | w_w_hs);
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Byte-lane array update.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < c_BYTES; i++) begin
        if (w_wstrb_eff[i]) begin
          r_mem[w_aw_idx][i*8 +: 8] <= w_wdata_eff[i*8 +: 8];
        end
      end
    end
  end

  // Byte-offset address bits carry no meaning for word-wide accesses.
  logic w_unused;
  assign w_unused = ^{araddr[c_OFF_W-1:0], w_aw_addr[c_OFF_W-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_s.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_sram_s
// Purpose  : Self-checking bench for axi_lite_sram_s. One instance with
//            RD_LAT=1 carries most scenarios, a second with RD_LAT=4 covers
//            the long-latency stall case. Expected R/B responses are queued
//            when stimulus is issued and popped by negedge monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_sram_s;

  localparam logic [31:0] c_BASE = 32'h8000_0000;
  localparam int          c_SPAN = 1024 * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // RD_LAT = 1 instance
  logic [31:0] araddr = '0;  logic arvalid = 1'b0; logic arready;
  logic [63:0] rdata;        logic [1:0] rresp;    logic rvalid;  logic rready = 1'b0;
  logic [31:0] awaddr = '0;  logic awvalid = 1'b0; logic awready;
  logic [63:0] wdata = '0;   logic [7:0] wstrb = '0; logic wvalid = 1'b0; logic wready;
  logic [1:0]  bresp;        logic bvalid;         logic bready = 1'b0;
  // RD_LAT = 4 instance
  logic [31:0] araddr4 = '0; logic arvalid4 = 1'b0; logic arready4;
  logic [63:0] rdata4;       logic [1:0] rresp4;    logic rvalid4; logic rready4 = 1'b0;
  logic [31:0] awaddr4 = '0; logic awvalid4 = 1'b0; logic awready4;
  logic [63:0] wdata4 = '0;  logic [7:0] wstrb4 = '0; logic wvalid4 = 1'b0; logic wready4;
  logic [1:0]  bresp4;       logic bvalid4;         logic bready4 = 1'b0;

  axi_lite_sram_s #(.ADDR_W(32), .DATA_W(64), .DEPTH(1024), .BASE(32'h8000_0000), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_lite_sram_s #(.ADDR_W(32), .DATA_W(64), .DEPTH(1024), .BASE(32'h8000_0000), .RD_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .araddr(araddr4), .arvalid(arvalid4), .arready(arready4),
    .rdata(rdata4), .rresp(rresp4), .rvalid(rvalid4), .rready(rready4),
    .awaddr(awaddr4), .awvalid(awvalid4), .awready(awready4),
    .wdata(wdata4), .wstrb(wstrb4), .wvalid(wvalid4), .wready(wready4),
    .bresp(bresp4), .bvalid(bvalid4), .bready(bready4)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  r;
  } rexp_t;

  rexp_t       rq[$];
  rexp_t       rq4[$];
  logic [1:0]  bq[$];
  logic [1:0]  bq4[$];
  logic [63:0] model[int];
  int          n_chk  = 0;
  int          n_fail = 0;

  // --------------------------------------------------------------------------
  // Scoreboard monitors: a handshake seen at negedge completes at the next
  // posedge, so each response is popped exactly once.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rvalid && rready) begin
      rexp_t e;
      n_chk++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL r_unexpected: got rdata=%h rresp=%0d, required no response", rdata, rresp);
      end else begin
        e = rq.pop_front();
        if ({rdata, rresp} !== e) begin
          n_fail++;
          $display("FAIL r_data: got rdata=%h rresp=%0d, required rdata=%h rresp=%0d", rdata, rresp, e.d, e.r);
        end
      end
    end
    if (bvalid && bready) begin
      logic [1:0] eb;
      n_chk++;
      if (bq.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected: got bresp=%0d, required no response", bresp);
      end else begin
        eb = bq.pop_front();
        if (bresp !== eb) begin
          n_fail++;
          $display("FAIL b_resp: got %0d, required %0d", bresp, eb);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid4 && rready4) begin
      rexp_t e;
      n_chk++;
      if (rq4.size() == 0) begin
        n_fail++;
        $display("FAIL r4_unexpected: got rdata=%h, required no response", rdata4);
      end else begin
        e = rq4.pop_front();
        if ({rdata4, rresp4} !== e) begin
          n_fail++;
          $display("FAIL r4_data: got rdata=%h rresp=%0d, required rdata=%h rresp=%0d", rdata4, rresp4, e.d, e.r);
        end
      end
    end
    if (bvalid4 && bready4) begin
      logic [1:0] eb;
      n_chk++;
      if (bq4.size() == 0) begin
        n_fail++;
        $display("FAIL b4_unexpected: got bresp=%0d, required no response", bresp4);
      end else begin
        eb = bq4.pop_front();
        if (bresp4 !== eb) begin
          n_fail++;
          $display("FAIL b4_resp: got %0d, required %0d", bresp4, eb);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Model and drivers (dut, RD_LAT = 1)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= c_BASE) && (a < c_BASE + 32'(c_SPAN));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - c_BASE) >> 3);
  endfunction

  task automatic exp_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input bit push);
    int k;
    logic [63:0] w;
    if (in_rng(a)) begin
      k = widx(a);
      w = model.exists(k) ? model[k] : 64'd0;
      for (int i = 0; i < 8; i++) if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
      model[k] = w;
      if (push) bq.push_back(2'b00);
    end else if (push) begin
      bq.push_back(2'b11);
    end
  endtask

  task automatic exp_read(input logic [31:0] a);
    rexp_t e;
    if (in_rng(a)) begin
      e.d = model.exists(widx(a)) ? model[widx(a)] : 64'd0;
      e.r = 2'b00;
    end else begin
      e.d = 64'd0;
      e.r = 2'b11;
    end
    rq.push_back(e);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    bit seen;
    exp_write(a, d, s, 1'b1);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
      logic ah, wh;
      ah = awvalid & awready;
      wh = wvalid & wready;
      tick();
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
    end
    n_chk++;
    if (awvalid || wvalid) begin
      n_fail++;
      $display("FAIL aw_w_accept: got awvalid/wvalid still pending=%b%b, required 00", awvalid, wvalid);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    bready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bvalid) begin
        seen = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bready = 1'b0;
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL b_timeout: got no bvalid, required a response at 0x%h", a);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int exp_lat);
    int lat;
    exp_read(a);
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 20 && arvalid; n++) begin
      logic h;
      h = arready;
      tick();
      if (h) arvalid = 1'b0;
    end
    n_chk++;
    if (arvalid) begin
      n_fail++;
      $display("FAIL ar_accept: got no AR handshake, required one at 0x%h", a);
      arvalid = 1'b0;
      return;
    end
    lat = 0;
    while (!rvalid && lat < 30) begin
      tick();
      lat++;
    end
    n_chk++;
    if (!rvalid || (exp_lat > 0 && lat != exp_lat)) begin
      n_fail++;
      $display("FAIL r_latency: got %0d cycles (rvalid=%b), required %0d", lat, rvalid, exp_lat);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    n_chk++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_fail++;
      $display("FAIL r_release: got rvalid=%b arready=%b, required rvalid=0 arready=1", rvalid, arready);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b%b%b v=%b%b rresp=%0d bresp=%0d rdata=%h, required all 0",
               arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata);
    end
    n_chk++;
    if ({arready4, awready4, wready4, rvalid4, bvalid4, rdata4} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs4: got rdy=%b%b%b v=%b%b, required all 0", arready4, awready4, wready4, rvalid4, bvalid4);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if ({arready, awready, wready, arready4, awready4, wready4} !== 6'b111111) begin
      n_fail++;
      $display("FAIL reset_release: got %b%b%b %b%b%b, required 111 111",
               arready, awready, wready, arready4, awready4, wready4);
    end
  endtask

  task automatic test_full_write_read();
    do_write(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF);
    do_read (32'h8000_0008, 1);
  endtask

  task automatic test_partial_strobe();
    do_write(32'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
    do_read (32'h8000_0008, 1);
    // an all-zero strobe is a legal no-op write
    do_write(32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    do_read (32'h8000_0008, 1);
  endtask

  task automatic test_w_before_aw();
    exp_write(32'h8000_0010, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1'b1);
    wdata = 64'h0F0E_0D0C_0B0A_0908; wstrb = 8'hFF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      n_chk++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL w_first_hold: got wready=%b awready=%b bvalid=%b, required 0 1 0", wready, awready, bvalid);
      end
      tick();
    end
    awaddr = 32'h8000_0010; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      n_chk++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
        n_fail++;
        $display("FAIL b_stall: got bvalid=%b bresp=%0d, required bvalid=1 bresp=0", bvalid, bresp);
      end
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      n_chk++;
      if (bvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL b_single_pulse: got bvalid=%b, required 0", bvalid);
      end
      tick();
    end
    do_read(32'h8000_0010, 1);
    // AW and W together
    do_write(32'h8000_0018, 64'h0102_0304_0506_0708, 8'hFF);
    n_chk++;
    if (bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b_single_pulse2: got bvalid=%b, required 0", bvalid);
    end
    do_read(32'h8000_0018, 1);
  endtask

  task automatic test_out_of_range();
    do_write(32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    do_read (32'h0000_0000, 1);
    do_write(32'h9000_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    do_write(32'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    do_read (32'h8000_2000, 1);
    do_read (32'h8000_0000, 1);
    do_write(32'h8000_1FF8, 64'h5A5A_5A5A_A5A5_A5A5, 8'hFF);
    do_read (32'h8000_1FF8, 1);
  endtask

  task automatic test_same_edge();
    exp_read(32'h8000_0018);
    exp_write(32'h8000_0018, 64'h7777_6666_5555_4444, 8'hFF, 1'b1);
    araddr = 32'h8000_0018; arvalid = 1'b1;
    awaddr = 32'h8000_0018; awvalid = 1'b1;
    wdata = 64'h7777_6666_5555_4444; wstrb = 8'hFF; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    n_chk++;
    if ({arready, awready, wready} !== 3'b000) begin
      n_fail++;
      $display("FAIL same_edge_accept: got %b%b%b, required 000", arready, awready, wready);
    end
    rready = 1'b1; bready = 1'b1;
    repeat (4) tick();
    rready = 1'b0; bready = 1'b0;
    do_read(32'h8000_0018, 1);
  endtask

  task automatic test_rd_lat4();
    rexp_t e;
    int    lat;
    bit    ar_low;
    bq4.push_back(2'b00);
    awaddr4 = 32'h8000_0020; awvalid4 = 1'b1;
    wdata4 = 64'hCAFE_F00D_1234_5678; wstrb4 = 8'hFF; wvalid4 = 1'b1;
    tick();
    awvalid4 = 1'b0; wvalid4 = 1'b0;
    bready4 = 1'b1;
    repeat (3) tick();
    bready4 = 1'b0;
    e.d = 64'hCAFE_F00D_1234_5678; e.r = 2'b00;
    rq4.push_back(e);
    araddr4 = 32'h8000_0020; arvalid4 = 1'b1;
    n_chk++;
    if (arready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL lat4_arready: got %b, required 1", arready4);
    end
    tick();
    arvalid4 = 1'b0;
    lat = 0;
    ar_low = 1'b1;
    while (!rvalid4 && lat < 30) begin
      if (arready4 !== 1'b0) ar_low = 1'b0;
      tick();
      lat++;
    end
    n_chk++;
    if (lat != 4 || !rvalid4 || !ar_low) begin
      n_fail++;
      $display("FAIL lat4_latency: got %0d cycles (arready low=%b), required 4 (1)", lat, ar_low);
    end
    for (int n = 0; n < 3; n++) begin
      n_chk++;
      if ({rvalid4, arready4, rdata4, rresp4} !== {1'b1, 1'b0, e.d, e.r}) begin
        n_fail++;
        $display("FAIL lat4_stall: got v=%b ar=%b rdata=%h rresp=%0d, required v=1 ar=0 rdata=%h rresp=0",
                 rvalid4, arready4, rdata4, rresp4, e.d);
      end
      tick();
    end
    rready4 = 1'b1;
    tick();
    rready4 = 1'b0;
    n_chk++;
    if (rvalid4 !== 1'b0 || arready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL lat4_release: got rvalid=%b arready=%b, required 0 1", rvalid4, arready4);
    end
  endtask

  task automatic test_reset_midflight();
    // write reaches W_RESP; its array edge has happened, its response is dropped
    exp_write(32'h8000_0030, 64'h3333_2222_1111_0000, 8'hFF, 1'b0);
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    wdata = 64'h3333_2222_1111_0000; wstrb = 8'hFF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h8000_0030; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n_chk++;
    if ({bvalid, arready, rvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL midflight_state: got bvalid=%b arready=%b rvalid=%b, required 1 0 0", bvalid, arready, rvalid);
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if ({rvalid, bvalid, arready, awready, wready} !== 5'b00000) begin
      n_fail++;
      $display("FAIL midflight_reset: got %b%b%b%b%b, required 00000", rvalid, bvalid, arready, awready, wready);
    end
    rst = 1'b0;
    rready = 1'b1; bready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      n_chk++;
      if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL midflight_no_resp: got rvalid=%b bvalid=%b, required 0 0", rvalid, bvalid);
      end
    end
    rready = 1'b0; bready = 1'b0;
    do_write(32'h8000_0038, 64'h9999_8888_7777_6666, 8'hFF);
    do_read (32'h8000_0038, 1);
    do_read (32'h8000_0030, 1);
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_partial_strobe();
    test_w_before_aw();
    test_out_of_range();
    test_same_edge();
    test_rd_lat4();
    test_reset_midflight();
    repeat (3) tick();
    n_chk++;
    if (rq.size() + bq.size() + rq4.size() + bq4.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d/%0d pending, required 0",
               rq.size(), bq.size(), rq4.size(), bq4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_sram_s.md
AXI_LITE_SRAM_S -- requirements
Module: axi_lite_sram_s

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI-lite address width.
REQ-002 SHALL have parameter DATA_W, default 64: data width in bits, one of 32 or 64.
REQ-003 SHALL have parameter DEPTH, default 1024: number of DATA_W words; power of two.
REQ-004 SHALL have parameter BASE, default 32'h8000_0000: byte address of word 0; DEPTH*DATA_W/8 aligned.
REQ-005 SHALL have parameter RD_LAT, default 1: cycles from AR handshake to rvalid; legal range 1..15.
REQ-006 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports araddr  input  ADDR_W, arvalid  input  1, arready  output  1: read address channel.
REQ-009 SHALL have ports rdata  output  DATA_W, rresp  output  2, rvalid  output  1, rready  input  1: read data channel.
REQ-010 SHALL have ports awaddr  input  ADDR_W, awvalid  input  1, awready  output  1: write address channel.
REQ-011 SHALL have ports wdata  input  DATA_W, wstrb  input  DATA_W/8, wvalid  input  1, wready  output  1: write data channel.
REQ-012 SHALL have ports bresp  output  2, bvalid  output  1, bready  input  1: write response channel.

Function
REQ-013 SHALL hold a DEPTH x DATA_W storage array that is not cleared by reset.
REQ-014 SHALL decode addresses as follows: in range iff BASE <= addr < BASE+DEPTH*DATA_W/8; word index = (addr-BASE) >> log2(DATA_W/8); the low byte-offset bits are ignored.
REQ-015 SHALL implement a read FSM with states R_IDLE, R_WAIT and R_RESP.
REQ-016 SHALL drive arready = 1 only in R_IDLE.
REQ-017 SHALL, on AR handshake (arvalid & arready), capture the array word (0 if out of range) into an rdata holding register at that edge, load a latency counter with RD_LAT-1, and enter R_WAIT.
REQ-018 SHALL, in R_WAIT, decrement the counter each cycle and enter R_RESP after the cycle in which it is 0, so rvalid first rises RD_LAT cycles after the handshake edge.
REQ-019 SHALL, in R_RESP, hold rvalid = 1 with rdata and rresp stable until rready; rresp = 2'b00 (OKAY) if in range, 2'b11 (DECERR) otherwise.
REQ-020 SHALL, on R handshake, return to R_IDLE with rvalid = 0 the next cycle; back-to-back reads are therefore spaced RD_LAT+2 cycles minimum.
REQ-021 SHALL implement a write FSM with states W_IDLE and W_RESP.
REQ-022 SHALL, in W_IDLE, accept AW and W independently in any order or in the same cycle: awready = 1 until AW is captured, wready = 1 until W is captured, then 0 until return to W_IDLE.
REQ-023 SHALL, on the edge where both AW and W are held (captured earlier or handshaking now), write each byte lane i with wstrb[i] = 1 if in range, and enter W_RESP.
REQ-024 SHALL, in W_RESP, hold bvalid = 1 with bresp = 2'b00 if in range, or 2'b11 with no array update if out of range, until bready; on B handshake, return to W_IDLE with all write captures cleared.
REQ-025 SHALL run the read and write FSMs concurrently and independently.
REQ-026 SHALL resolve a same-word read and write on the same edge so that the read returns the pre-write data.
REQ-027 SHALL treat wstrb = 0 as a legal write: no bytes change and the response is OKAY.

Reset
REQ-028 SHALL, while rst = 1, enter R_IDLE and W_IDLE and clear all captures and counters.
REQ-029 SHALL, while rst = 1, drive arready = 0, awready = 0, wready = 0, rvalid = 0, bvalid = 0, rresp = 0, bresp = 0 and rdata = 0.
REQ-030 SHALL, in the first cycle after reset deasserts, drive arready = 1, awready = 1 and wready = 1.
REQ-031 SHALL abandon any transaction in flight when rst asserts mid-operation, leave array contents unchanged unless the write edge already occurred, and issue no response for the abandoned transaction.

Verification
REQ-032 SHALL be covered by this scenario: DATA_W=64, RD_LAT=1; write 0x8000_0008 data 0x1122334455667788, wstrb 0xFF -> bresp 0; read 0x8000_0008 -> rvalid exactly 1 cycle after AR handshake, rdata 0x1122334455667788, rresp 0.
REQ-033 SHALL be covered by this scenario: partial strobe 0x0F with wdata 0xAAAAAAAA_BBBBBBBB onto the word above -> readback 0x11223344_BBBBBBBB.
REQ-034 SHALL be covered by this scenario: W sent 3 cycles before AW, then AW and W in the same cycle -> each gives exactly one bvalid pulse, held until bready; bready held low 5 cycles -> bvalid stays 1 and bresp stays stable.
REQ-035 SHALL be covered by this scenario: read 0x0000_0000 and write 0x9000_0000 (out of range) -> rresp 2'b11 with rdata 0, bresp 2'b11, and the array is unchanged.
REQ-036 SHALL be covered by this scenario: RD_LAT=4 with rready low 3 cycles -> rvalid rises 4 cycles after the handshake, data is stable while stalled, and arready is low until the cycle after the R handshake.
REQ-037 SHALL be covered by this scenario: rst pulsed while in R_WAIT and in W_RESP -> all valid outputs 0 the next cycle, no later response, and the next read/write pair completes normally.
